// File: rtl/pattern_detector_param_if.sv
// Serial-detector bus: stream input, pattern control and match outputs.
// PATTERN_MASK_EN adds the pat_mask don't-care vector.
interface pattern_detector_param_if #(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 8
);
  logic             datain;
  logic             din_valid;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_value;
`ifdef PATTERN_MASK_EN
  logic [PAT_W-1:0] pat_mask;
`endif
  logic             cnt_clr;
  logic             pattern_detected;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  // Source of the stream and control
  modport master (
    output datain, din_valid, overlap_en, pat_load, pat_value,
`ifdef PATTERN_MASK_EN
    output pat_mask,
`endif
    output cnt_clr,
    input  pattern_detected, match_count, count_sat
  );

  // Detector side
  modport slave (
    input  datain, din_valid, overlap_en, pat_load, pat_value,
`ifdef PATTERN_MASK_EN
    input  pat_mask,
`endif
    input  cnt_clr,
    output pattern_detected, match_count, count_sat
  );
endinterface

// File: rtl/pattern_detector_param.sv
// Programmable PAT_W-bit serial pattern detector with saturating match count.
// Optional feature macro: PATTERN_MASK_EN (per-bit don't-care mask, reset all-ones).
module pattern_detector_param #(
  parameter int unsigned      PAT_W    = 3,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(3'b101),
  parameter int unsigned      CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pattern_detector_param_if.slave   bus
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-1:0]  shreg_q, shreg_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              det_q,   det_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              sat_q,   sat_d;
`ifdef PATTERN_MASK_EN
  logic [PAT_W-1:0]  mask_q,  mask_d;
`endif

  logic              accept_c;
  logic              full_c;
  logic              match_c;
  logic [PAT_W-1:0]  shreg_nxt_c;

  // Match decision for the bit being accepted this cycle
  always_comb begin
    accept_c    = bus.din_valid & ~bus.pat_load;
    shreg_nxt_c = {shreg_q[PAT_W-2:0], bus.datain};
    full_c      = (fill_q >= FILL_W'(PAT_W - 1));
`ifdef PATTERN_MASK_EN
    match_c     = accept_c & full_c & (((shreg_nxt_c ^ pat_q) & mask_q) == '0);
`else
    match_c     = accept_c & full_c & (shreg_nxt_c == pat_q);
`endif
  end

  // Next state of pattern, history, fill and counters
  always_comb begin
    pat_d   = pat_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    det_d   = match_c;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
`ifdef PATTERN_MASK_EN
    mask_d  = mask_q;
`endif

    if (bus.pat_load) begin
      // Reload discards the incoming bit and restarts the history
      pat_d   = bus.pat_value;
`ifdef PATTERN_MASK_EN
      mask_d  = bus.pat_mask;
`endif
      shreg_d = '0;
      fill_d  = '0;
    end else if (bus.din_valid) begin
      if (match_c && !bus.overlap_en) begin
        shreg_d = '0;
        fill_d  = '0;
      end else begin
        shreg_d = shreg_nxt_c;
        if (fill_q != FILL_W'(PAT_W)) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end

    // Clear first so a coincident match counts as the first one
    if (bus.cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
    if (match_c) begin
      if (cnt_d == '1) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_INIT;
      shreg_q <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
`ifdef PATTERN_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
`ifdef PATTERN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign bus.pattern_detected = det_q;
  assign bus.match_count      = cnt_q;
  assign bus.count_sat        = sat_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: two instances (CNT_W=8 / PAT 101 and
// CNT_W=2 / PAT 111) driven by one stream, checked against a queue model.
module tb_pattern_detector_param;

  localparam int unsigned PAT_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  bit   ov;
  int   checks   = 0;
  int   failures = 0;

  pattern_detector_param_if #(.PAT_W(PAT_W), .CNT_W(8)) bus0 ();
  pattern_detector_param_if #(.PAT_W(PAT_W), .CNT_W(2)) bus1 ();

  pattern_detector_param #(.PAT_W(PAT_W), .PAT_INIT(3'b101), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  pattern_detector_param #(.PAT_W(PAT_W), .PAT_INIT(3'b111), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  // Model: history of accepted bits since the last restart, oldest first
  bit         hist [2][$];
  logic [2:0] m_pat  [2];
  logic [2:0] m_mask [2];
  bit         m_det  [2];
  int         m_cnt  [2];
  bit         m_sat  [2];
  int         cmax   [2] = '{255, 3};

  function automatic void model_reset(int k);
    m_pat[k]  = (k == 0) ? 3'b101 : 3'b111;
    m_mask[k] = 3'b111;
    hist[k].delete();
    m_det[k]  = 1'b0;
    m_cnt[k]  = 0;
    m_sat[k]  = 1'b0;
  endfunction

  function automatic void model_step(int k, bit d, bit dv, bit ld, logic [2:0] pv,
                                     logic [2:0] pm, bit ovl, bit clr);
    bit m = 1'b0;
    if (ld) begin
      m_pat[k]  = pv;
      m_mask[k] = pm;
      hist[k].delete();
    end else if (dv) begin
      hist[k].push_back(d);
      if (hist[k].size() > PAT_W) void'(hist[k].pop_front());
      if (hist[k].size() == PAT_W) begin
        m = 1'b1;
        for (int i = 0; i < PAT_W; i++)
          if (m_mask[k][PAT_W-1-i] && (hist[k][i] != m_pat[k][PAT_W-1-i])) m = 1'b0;
      end
      if (m && !ovl) hist[k].delete();
    end
    m_det[k] = m;
    if (clr) begin
      m_cnt[k] = 0;
      m_sat[k] = 1'b0;
    end
    if (m) begin
      if (m_cnt[k] == cmax[k]) m_sat[k] = 1'b1;
      else m_cnt[k] = m_cnt[k] + 1;
    end
  endfunction

  // Advance the model on the same events as the DUTs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
`ifdef PATTERN_MASK_EN
      model_step(0, bus0.datain, bus0.din_valid, bus0.pat_load, bus0.pat_value,
                 bus0.pat_mask, bus0.overlap_en, bus0.cnt_clr);
      model_step(1, bus1.datain, bus1.din_valid, bus1.pat_load, bus1.pat_value,
                 bus1.pat_mask, bus1.overlap_en, bus1.cnt_clr);
`else
      model_step(0, bus0.datain, bus0.din_valid, bus0.pat_load, bus0.pat_value,
                 3'b111, bus0.overlap_en, bus0.cnt_clr);
      model_step(1, bus1.datain, bus1.din_valid, bus1.pat_load, bus1.pat_value,
                 3'b111, bus1.overlap_en, bus1.cnt_clr);
`endif
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (bus0.pattern_detected !== m_det[0] || bus0.match_count !== 8'(m_cnt[0]) ||
        bus0.count_sat !== m_sat[0]) begin
      failures++;
      $display("FAIL cmp_dut0 t=%0t act det=%b cnt=%0d sat=%b exp det=%b cnt=%0d sat=%b",
               $time, bus0.pattern_detected, bus0.match_count, bus0.count_sat,
               m_det[0], m_cnt[0], m_sat[0]);
    end
    checks++;
    if (bus1.pattern_detected !== m_det[1] || bus1.match_count !== 2'(m_cnt[1]) ||
        bus1.count_sat !== m_sat[1]) begin
      failures++;
      $display("FAIL cmp_dut1 t=%0t act det=%b cnt=%0d sat=%b exp det=%b cnt=%0d sat=%b",
               $time, bus1.pattern_detected, bus1.match_count, bus1.count_sat,
               m_det[1], m_cnt[1], m_sat[1]);
    end
  end

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the active edge
  task automatic step(bit d, bit dv, bit ld = 1'b0, logic [2:0] pv = 3'b101,
                      logic [2:0] pm = 3'b111, bit clr = 1'b0);
    @(negedge clk);
    #1;
    bus0.datain = d;   bus1.datain = d;
    bus0.din_valid = dv; bus1.din_valid = dv;
    bus0.pat_load = ld;  bus1.pat_load = ld;
    bus0.pat_value = pv; bus1.pat_value = 3'b111;
`ifdef PATTERN_MASK_EN
    bus0.pat_mask = pm;  bus1.pat_mask = 3'b111;
`endif
    bus0.cnt_clr = clr;  bus1.cnt_clr = clr;
    bus0.overlap_en = ov; bus1.overlap_en = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic bits(logic [5:0] v, int n);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    ov    = 1'b1;
    bus0.datain = 0; bus0.din_valid = 0; bus0.pat_load = 0; bus0.pat_value = 3'b101;
    bus0.cnt_clr = 0; bus0.overlap_en = 1;
    bus1.datain = 0; bus1.din_valid = 0; bus1.pat_load = 0; bus1.pat_value = 3'b111;
    bus1.cnt_clr = 0; bus1.overlap_en = 1;
`ifdef PATTERN_MASK_EN
    bus0.pat_mask = 3'b111; bus1.pat_mask = 3'b111;
`endif
    #23;
    lit("reset_det", 32'(bus0.pattern_detected), 0);
    lit("reset_cnt", 32'(bus0.match_count), 0);
    lit("reset_sat", 32'(bus0.count_sat), 0);
    rst_n = 1'b1;

    // Overlap: 1,0,1,0,1 -> pulses after bits 3 and 5
    ov = 1'b1;
    step(1, 1); step(0, 1);
    step(1, 1); lit("t1_bit3_det", 32'(bus0.pattern_detected), 1);
    step(0, 1); lit("t1_bit4_det", 32'(bus0.pattern_detected), 0);
    step(1, 1); lit("t1_bit5_det", 32'(bus0.pattern_detected), 1);
    lit("t1_count", 32'(bus0.match_count), 2);

    // Non-overlap: fresh history and cleared count, single pulse
    ov = 1'b0;
    step(0, 0, 1'b1, 3'b101, 3'b111, 1'b1);
    lit("t2_clr_count", 32'(bus0.match_count), 0);
    step(1, 1); step(0, 1);
    step(1, 1); lit("t2_bit3_det", 32'(bus0.pattern_detected), 1);
    step(0, 1); step(1, 1);
    lit("t2_bit5_det", 32'(bus0.pattern_detected), 0);
    lit("t2_count", 32'(bus0.match_count), 1);

    // din_valid gaps hold the history
    ov = 1'b1;
    step(1, 1); step(1, 0); step(0, 1); step(0, 0);
    step(1, 1); lit("gap_det", 32'(bus0.pattern_detected), 1);
    step(1, 0); lit("gap_idle_det", 32'(bus0.pattern_detected), 0);

    // Reset mid-stream discards a partial pattern
    step(0, 0, 1'b1, 3'b101);
    step(1, 1); step(0, 1);
    #2 rst_n = 1'b0;
    #1;
    lit("t3_rst_det", 32'(bus0.pattern_detected), 0);
    lit("t3_rst_cnt", 32'(bus0.match_count), 0);
    step(0, 0);
    #2 rst_n = 1'b1;
    step(1, 1); lit("t3_post_rst_det", 32'(bus0.pattern_detected), 0);
    step(1, 1); step(0, 1);
    step(1, 1); lit("t3_match_det", 32'(bus0.pattern_detected), 1);

    // Load wins over valid data; new pattern 110
    step(1, 1, 1'b1, 3'b110);
    lit("t4_load_det", 32'(bus0.pattern_detected), 0);
    step(1, 1); step(1, 1);
    step(0, 1); lit("t4_110_det", 32'(bus0.pattern_detected), 1);
    step(1, 1); step(0, 1);
    step(1, 1); lit("t4_101_det", 32'(bus0.pattern_detected), 0);

    // Saturation on the CNT_W=2 instance (pattern 111)
    ov = 1'b1;
    step(0, 0, 1'b1, 3'b101, 3'b111, 1'b1);
    step(1, 1); step(1, 1);
    step(1, 1); lit("t5_cnt1", 32'(bus1.match_count), 1);
    step(1, 1); lit("t5_cnt2", 32'(bus1.match_count), 2);
    step(1, 1); lit("t5_cnt3", 32'(bus1.match_count), 3);
    lit("t5_sat_pre", 32'(bus1.count_sat), 0);
    step(1, 1); lit("t5_hold", 32'(bus1.match_count), 3);
    lit("t5_sat", 32'(bus1.count_sat), 1);
    step(0, 0, 1'b0, 3'b101, 3'b111, 1'b1);
    lit("t5_clr_cnt", 32'(bus1.match_count), 0);
    lit("t5_clr_sat", 32'(bus1.count_sat), 0);
    step(1, 1, 1'b0, 3'b101, 3'b111, 1'b1);
    lit("t5_clr_match_det", 32'(bus1.pattern_detected), 1);
    lit("t5_clr_match_cnt", 32'(bus1.match_count), 1);

`ifdef PATTERN_MASK_EN
    // Middle bit is don't-care
    ov = 1'b0;
    step(0, 0, 1'b1, 3'b101, 3'b101);
    bits(6'b101, 3); lit("t6_101_det", 32'(bus0.pattern_detected), 1);
    bits(6'b111, 3); lit("t6_111_det", 32'(bus0.pattern_detected), 1);
    bits(6'b001, 3); lit("t6_001_det", 32'(bus0.pattern_detected), 0);
    step(0, 0, 1'b1, 3'b000, 3'b000);
    bits(6'b010, 3); lit("t6_allx_det", 32'(bus0.pattern_detected), 1);
`endif

    // Mixed stream checked only by the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) ov = ~ov;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) == 0), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
    end

    step(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
